// File: rtl/div_seq.sv
// Iterative signed restoring divider: one quotient bit per cycle, then a sign-fix cycle.
// Flags divide-by-zero and the single overflowing case (most-negative / -1) on checkDiv.
`timescale 1ns/1ps
module div_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             checkDiv,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST   = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MAXPOS = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_qd;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_abs_b;
    logic [WIDTH-1:0] r_a;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_zero;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_qd_nx;
    logic             w_b_zero;

    assign w_abs_a  = a[WIDTH-1] ? -a : a;
    assign w_abs_b  = b[WIDTH-1] ? -b : b;
    assign w_b_zero = (b == '0);

    // The partial remainder is always below |b| after an iteration, so WIDTH bits
    // of storage suffice; only the shifted trial value needs the extra bit.
    assign w_rem_sh = {r_rem, r_qd[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_abs_b};
    assign w_ge     = ~w_diff[WIDTH];
    assign w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_qd_nx  = {r_qd[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = w_b_zero ? FIX : CALC;
                end
            end
            CALC: begin
                if (r_count == LAST) begin
                    w_next = FIX;
                end
            end
            FIX: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_qd     <= '0;
            r_rem    <= '0;
            r_abs_b  <= '0;
            r_a      <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_zero   <= 1'b0;
            q        <= '0;
            r        <= '0;
            checkDiv <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_abs_b  <= w_abs_b;
                        r_sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_sign_r <= a[WIDTH-1];
                        r_zero   <= w_b_zero;
                        r_count  <= '0;
                        r_rem    <= '0;
                        r_qd     <= w_abs_a;
                        busy     <= ~w_b_zero;
                    end
                end
                CALC: begin
                    r_rem   <= w_rem_nx;
                    r_qd    <= w_qd_nx;
                    r_count <= r_count + CW'(1);
                end
                FIX: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (r_zero) begin
                        q        <= '0;
                        r        <= r_a;
                        checkDiv <= 1'b1;
                    end else begin
                        q        <= r_sign_q ? -r_qd : r_qd;
                        r        <= r_sign_r ? -r_rem : r_rem;
                        checkDiv <= (~r_sign_q) && (r_qd > MAXPOS);
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Randomized self-checking bench for div_seq against an integer-arithmetic reference.
`timescale 1ns/1ps
module tb_div_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       checkDiv;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    div_seq #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .q        (q),
        .r        (r),
        .checkDiv (checkDiv),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: C-style integer division (truncation toward zero, remainder follows dividend)
    function automatic void model(input logic [7:0] ta, input logic [7:0] tb_,
                                  output logic [7:0] eq, output logic [7:0] er,
                                  output logic ef);
        int ia, ib, iq, ir;
        ia = $signed(ta);
        ib = $signed(tb_);
        if (ib == 0) begin
            eq = 8'h00;
            er = ta;
            ef = 1'b1;
        end else begin
            iq = ia / ib;
            ir = ia % ib;
            ef = (iq > 127);
            eq = iq[7:0];
            er = ir[7:0];
        end
    endfunction

    // Launches one operation and waits (bounded) for done; now=1 drives start immediately.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input bit now,
                          output int lat, output int nbusy);
        if (!now) @(negedge clk);
        a = ta;
        b = tb_;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        lat = 0;
        nbusy = busy ? 1 : 0;
        while (!done && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) nbusy++;
        end
    endtask

    task automatic verify(input logic [7:0] ta, input logic [7:0] tb_, input bit now);
        logic [7:0] eq, er;
        logic       ef;
        int         lat, nbusy;
        model(ta, tb_, eq, er, ef);
        run_op(ta, tb_, now, lat, nbusy);
        check("latency", lat, (tb_ == 8'h00) ? 1 : 9);
        check("busy_cycles", nbusy, (tb_ == 8'h00) ? 0 : 9);
        check("busy_at_done", {31'b0, busy}, 0);
        check("q", {24'b0, q}, {24'b0, eq});
        check("r", {24'b0, r}, {24'b0, er});
        check("checkDiv", {31'b0, checkDiv}, {31'b0, ef});
    endtask

    initial begin
        int lat, nbusy, ndone;
        logic [7:0] ra, rb;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_q", {24'b0, q}, 0);
        check("rst_r", {24'b0, r}, 0);
        check("rst_flags", {29'b0, checkDiv, busy, done}, 0);
        @(negedge clk);
        rst = 1'b0;

        verify(8'd100, 8'd7, 0);
        verify(8'h9C, 8'd7, 0);
        verify(8'd100, 8'hF9, 0);
        verify(8'd7, 8'h00, 0);
        verify(8'h80, 8'hFF, 0);
        verify(8'h80, 8'h01, 0);
        verify(8'h80, 8'h80, 0);
        verify(8'h7F, 8'h80, 0);

        // A second start while busy must be ignored
        @(negedge clk);
        a = 8'd50; b = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a = 8'd9; b = 8'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ign_done_seen", {31'b0, done}, 1);
        check("ign_q", {24'b0, q}, 16);
        check("ign_r", {24'b0, r}, 2);
        // Start in the done cycle is accepted
        verify(8'd9, 8'd2, 1);
        check("back2back_q", {24'b0, q}, 4);
        check("back2back_r", {24'b0, r}, 1);

        // Reset mid-calculation aborts the operation
        @(negedge clk);
        a = 8'd100; b = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out", {8'b0, q, r, 5'b0, checkDiv, busy, done}, 0);
        ndone = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("midrst_quiet", ndone, 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        verify(8'd100, 8'd7, 0);

        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom);
            case ($urandom_range(0, 9))
                0:       rb = 8'h00;
                1:       rb = 8'hFF;
                2:       rb = 8'h01;
                default: rb = 8'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) ra = 8'h80;
            verify(ra, rb, ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
